// File: rtl/sample_dma_writer_if.sv
// Sample FIFO read port plus SDRAM write channel for the sample DMA writer.
// master = DMA writer side, slave = FIFO/SDRAM controller side.
interface sample_dma_writer_if #(
   parameter int AW = 24,
   parameter int DW = 16
);
   logic          fifo_empty;
   logic          fifo_rd;
   logic [DW-1:0] fifo_data;
   logic [AW-1:0] awaddr;
   logic [DW-1:0] wdata;
   logic          wvalid;
   logic          wready;

   modport master (
      input  fifo_empty, fifo_data, wready,
      output fifo_rd, awaddr, wdata, wvalid
   );

   modport slave (
      output fifo_empty, fifo_data, wready,
      input  fifo_rd, awaddr, wdata, wvalid
   );
endinterface

// File: rtl/sample_dma_writer.sv
// Drains the sample FIFO into a circular SDRAM ring, one word per ARM/FETCH/WRITE pass (>= 3 cycles/word).
// Holds the write in WRITE while wready is low; pauses FIFO reads while the ring is full (one slot kept free).
module sample_dma_writer #(
   parameter int AW = 24,
   parameter int DW = 16
) (
   input  logic               clk_48,
   input  logic               irst,
   input  logic               start,
   input  logic               stop,
   input  logic [AW-1:0]      cfg_base,
   input  logic [AW-1:0]      cfg_len,
   input  logic [AW-1:0]      rptr,
   sample_dma_writer_if.master bus,
   output logic [AW-1:0]      wptr,
   output logic               busy,
   output logic               full,
   output logic               overrun,
   output logic [31:0]        words
);
   typedef enum logic [1:0] {IDLE, ARM, FETCH, WRITE} state_t;

   state_t        state, state_nxt;
   logic          run;
   logic          clr_pend;
   logic [AW-1:0] base_q, len_q;
   logic [AW-1:0] wptr_inc;
   logic [AW-1:0] awaddr_q;
   logic [DW-1:0] wdata_q;
   logic          wvalid_q;
   logic          fifo_rd_c;
   logic          in_flight;
   logic          wr_done;
   logic          ovr_set;

   assign wptr_inc  = (wptr == len_q - AW'(1)) ? '0 : wptr + AW'(1);
   assign full      = (wptr_inc == rptr);
   assign in_flight = (state == FETCH) || (state == WRITE);
   assign wr_done   = (state == WRITE) && wvalid_q && bus.wready;
   assign ovr_set   = (state == ARM) && run && full && !bus.fifo_empty;
   assign busy      = run || (state != IDLE);

   assign bus.fifo_rd = fifo_rd_c;
   assign bus.awaddr  = awaddr_q;
   assign bus.wdata   = wdata_q;
   assign bus.wvalid  = wvalid_q;

   always_comb begin
      state_nxt = state;
      fifo_rd_c = 1'b0;
      case (state)
         IDLE:  if (start || run) state_nxt = ARM;
         ARM: begin
            // A start here only restarts the pointers; the FIFO is sampled again next cycle.
            if (start)                 state_nxt = ARM;
            else if (!run)             state_nxt = IDLE;
            else if (full)             state_nxt = ARM;
            else if (!bus.fifo_empty) begin
               fifo_rd_c = 1'b1;
               state_nxt = FETCH;
            end
         end
         FETCH: state_nxt = WRITE;
         WRITE: if (wr_done) state_nxt = ARM;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_48 or posedge irst) begin
      if (irst) begin
         state    <= IDLE;
         run      <= 1'b0;
         clr_pend <= 1'b0;
         base_q   <= '0;
         len_q    <= '0;
         wptr     <= '0;
         words    <= '0;
         overrun  <= 1'b0;
         awaddr_q <= '0;
         wdata_q  <= '0;
         wvalid_q <= 1'b0;
      end else begin
         state <= state_nxt;

         if (start) begin
            base_q  <= cfg_base;
            len_q   <= cfg_len;
            run     <= 1'b1;
            overrun <= 1'b0;
         end else begin
            if (stop)    run     <= 1'b0;
            if (ovr_set) overrun <= 1'b1;
         end

         // base_q/wptr are read before any same-cycle start takes effect,
         // so an in-flight word keeps its original address.
         if (state == FETCH) begin
            wdata_q  <= bus.fifo_data;
            awaddr_q <= base_q + wptr;
            wvalid_q <= 1'b1;
         end

         if (wr_done) begin
            wvalid_q <= 1'b0;
            clr_pend <= 1'b0;
            if (clr_pend || start) begin
               wptr  <= '0;
               words <= '0;
            end else begin
               wptr  <= wptr_inc;
               words <= words + 32'd1;
            end
         end else if (start) begin
            if (in_flight) begin
               clr_pend <= 1'b1;
            end else begin
               wptr  <= '0;
               words <= '0;
            end
         end
      end
   end
endmodule
